mdu_issue_ctrl: RTL and testbench

- Initiator side of the E-stage multiply/divide unit (MDU) start/busy protocol.
- Accepts MDU instructions (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) from the decode side through a valid/ready handshake, holding them in a one-entry buffer.
- Issues each buffered op to the MDU only when the MDU can take it, hides the one-cycle gap before MDU busy rises, and returns registered mfhi/mflo results.
- Handles interrupt/exception flush (req), and flags an MDU that stays busy too long.

---
 rtl/mdu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Initiator side of the MDU start/busy handshake: one-entry op buffer, issue gating
// around the MDU busy window, registered mfhi/mflo return and a stuck-busy timeout.
//
// state  | meaning
// IDLE   | MDU free; a buffered op issues here unless req flushes it
// ISSUED | start edge just happened; mdu_busy not visible yet, treat as busy
// WAIT   | wait for mdu_busy to fall, counting cycles toward TIMEOUT
module mdu_issue_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        in_ready,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_out,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          buf_full;
  logic [3:0]    buf_op;
  logic [31:0]   buf_a, buf_b;
  logic [CW-1:0] to_cnt, to_cnt_nxt;
  logic          err_nxt;
  logic          accept, issue, is_arith, is_mfx;

  assign in_ready = !buf_full;
  assign accept   = in_valid && !buf_full && !req;
  assign issue    = buf_full && (state == IDLE) && !req;
  assign is_arith = (buf_op[3:2] == 2'b00);
  assign is_mfx   = (buf_op[3:1] == 3'b010);

  always_comb begin
    mdu_start = 1'b0;
    mdu_op    = 4'b1111;
    mdu_a     = '0;
    mdu_b     = '0;
    if (issue) begin
      mdu_start = is_arith;
      mdu_op    = buf_op;
      mdu_a     = buf_a;
      mdu_b     = buf_b;
    end
  end

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    err_nxt    = err;
    case (state)
      IDLE: begin
        if (issue && is_arith) state_nxt = ISSUED;
      end
      ISSUED: begin
        state_nxt  = WAIT;
        to_cnt_nxt = '0;
      end
      WAIT: begin
        // to_cnt holds WAIT cycles already spent with busy high
        if (!mdu_busy) begin
          state_nxt = IDLE;
        end else if (to_cnt == CW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      to_cnt   <= '0;
      err      <= 1'b0;
      buf_full <= 1'b0;
      buf_op   <= '0;
      buf_a    <= '0;
      buf_b    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state    <= state_nxt;
      to_cnt   <= to_cnt_nxt;
      err      <= err_nxt;
      rd_valid <= issue && is_mfx;
      if (issue && is_mfx) rd_data <= mdu_out;
      // Undefined codes complete the handshake but never occupy the buffer
      if (accept) begin
        buf_full <= !in_op[3];
        buf_op   <= in_op;
        buf_a    <= in_a;
        buf_b    <= in_b;
      end else if (buf_full && (req || state == IDLE)) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: directed vector table, hand-written timeout/reset
// sequences and random traffic against a cycle-budget reference model.
module tb_mdu_issue_ctrl;
  localparam int TO    = 15;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset, req, in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic        in_ready, mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        mdu_busy;
  logic [31:0] mdu_out;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu_issue_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .in_valid(in_valid), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_ready(in_ready), .mdu_start(mdu_start),
    .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b), .mdu_busy(mdu_busy),
    .mdu_out(mdu_out), .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
  );

  function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      4'd0: r = sa * sb;
      4'd1: r = {32'b0, a} * {32'b0, b};
      4'd2: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {32'(sa % sb), 32'(sa / sb)};
      4'd3: if (b == 0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // MDU model: busy for mdu_lat cycles after a start edge, HI/LO readable combinationally
  logic [31:0] hi, lo;
  int busy_cnt;
  int mdu_lat = 5;
  assign mdu_busy = (busy_cnt != 0);
  assign mdu_out  = (mdu_op == 4'b0100) ? hi : lo;

  always @(posedge clk) begin
    if (reset) begin
      busy_cnt <= 0;
      hi       <= '0;
      lo       <= '0;
    end else if (mdu_start) begin
      busy_cnt <= mdu_lat;
      {hi, lo} <= mdu_calc(mdu_op, mdu_a, mdu_b);
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (mdu_op == 4'b0110) hi <= mdu_a;
      if (mdu_op == 4'b0111) lo <= mdu_a;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending ops and the first cycle the MDU may take a new one
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;
  rec_t        mq[$];
  int          cyc = 0;
  int          blocked_until = 0;
  int          err_at = NEVER;
  logic [31:0] hi_m = '0, lo_m = '0, rdd_m = '0;
  logic        rdv_m = 1'b0;

  task automatic step(input logic r, input logic q, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic e_ready, can, pop;
    rec_t h;
    reset = r; req = q; in_valid = v; in_op = op; in_a = a; in_b = b;
    #2;
    e_ready = (mq.size() == 0);
    can     = !e_ready && (cyc >= blocked_until) && !q;
    pop     = !e_ready && (q || cyc >= blocked_until);
    h       = '{4'hF, 32'h0, 32'h0};
    if (can) h = mq[0];
    if (!r) begin
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("mdu_start", 32'(mdu_start), 32'(can && h.op[3:2] == 2'b00));
      chk("mdu_op", 32'(mdu_op), 32'(h.op));
      if (can) begin
        chk("mdu_a", mdu_a, h.a);
        chk("mdu_b", mdu_b, h.b);
      end
      chk("rd_valid", 32'(rd_valid), 32'(rdv_m));
      chk("rd_data", rd_data, rdd_m);
      chk("err", 32'(err), 32'(cyc >= err_at));
    end
    if (r) begin
      mq.delete();
      blocked_until = 0;
      err_at = NEVER;
      hi_m = '0; lo_m = '0; rdd_m = '0; rdv_m = 1'b0;
    end else begin
      rdv_m = 1'b0;
      if (can) begin
        case (h.op)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            {hi_m, lo_m} = mdu_calc(h.op, h.a, h.b);
            if (mdu_lat - 1 >= TO) begin
              blocked_until = cyc + TO + 2;
              if (cyc + TO + 2 < err_at) err_at = cyc + TO + 2;
            end else begin
              blocked_until = cyc + mdu_lat + 2;
            end
          end
          4'd4: begin rdd_m = hi_m; rdv_m = 1'b1; end
          4'd5: begin rdd_m = lo_m; rdv_m = 1'b1; end
          4'd6: hi_m = h.a;
          default: lo_m = h.a;
        endcase
      end
      if (pop) void'(mq.pop_front());
      if (v && e_ready && !q && !op[3]) mq.push_back('{op, a, b});
    end
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst, rq, vld;
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat;
    logic        e_rdy, e_st;
    logic [3:0]  e_op;
    logic        e_rdv;
    logic [31:0] e_rdd;
  } vec_t;
  vec_t tbl[$];

  function automatic void row(input logic rst, input logic rq, input logic vld,
                              input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int lat, input logic e_rdy, input logic e_st,
                              input logic [3:0] e_op, input logic e_rdv, input logic [31:0] e_rdd);
    tbl.push_back('{rst, rq, vld, op, a, b, lat, e_rdy, e_st, e_op, e_rdv, e_rdd});
  endfunction

  initial begin
    reset = 1'b1; req = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    //  rst rq vld op     a             b             lat rdy st op     rdv rdd
    row(1, 0, 0, 4'h0, 32'h0,        32'h0,        5,  1, 0, 4'hF, 0, 32'h0);
    row(0, 0, 1, 4'h0, 32'd3,        32'hFFFF_FFFC, 5, 1, 0, 4'hF, 0, 32'h0);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        5,  0, 1, 4'h0, 0, 32'h0);
    row(0, 0, 1, 4'h5, 32'h0,        32'h0,        5,  1, 0, 4'hF, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      row(0, 0, 0, 4'h0, 32'h0,      32'h0,        5,  0, 0, 4'hF, 0, 32'h0);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        5,  0, 0, 4'h5, 0, 32'h0);
    row(0, 0, 1, 4'h4, 32'h0,        32'h0,        5,  1, 0, 4'hF, 1, 32'hFFFF_FFF4);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        5,  0, 0, 4'h4, 0, 32'hFFFF_FFF4);
    row(0, 0, 1, 4'h3, 32'd7,        32'd2,        3,  1, 0, 4'hF, 1, 32'hFFFF_FFFF);
    row(0, 0, 1, 4'h4, 32'h0,        32'h0,        3,  0, 1, 4'h3, 0, 32'hFFFF_FFFF);
    row(0, 0, 1, 4'h4, 32'h0,        32'h0,        3,  1, 0, 4'hF, 0, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++)
      row(0, 0, 0, 4'h0, 32'h0,      32'h0,        3,  0, 0, 4'hF, 0, 32'hFFFF_FFFF);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        3,  0, 0, 4'h4, 0, 32'hFFFF_FFFF);
    row(0, 0, 1, 4'h6, 32'hDEAD_BEEF, 32'h0,       3,  1, 0, 4'hF, 1, 32'h1);
    row(0, 0, 1, 4'h4, 32'h0,        32'h0,        3,  0, 0, 4'h6, 0, 32'h1);
    row(0, 0, 1, 4'h4, 32'h0,        32'h0,        3,  1, 0, 4'hF, 0, 32'h1);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        3,  0, 0, 4'h4, 0, 32'h1);
    row(0, 0, 1, 4'h0, 32'd5,        32'd6,        4,  1, 0, 4'hF, 1, 32'hDEAD_BEEF);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        4,  0, 1, 4'h0, 0, 32'hDEAD_BEEF);
    row(0, 0, 1, 4'h5, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 1, 0, 4'h0, 32'h0,        32'h0,        4,  0, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 0, 1, 4'h5, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        4,  0, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        4,  0, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 1, 0, 4'h0, 32'h0,        32'h0,        4,  0, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 1, 1, 4'h4, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 0, 1, 4'h5, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'hDEAD_BEEF);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        4,  0, 0, 4'h5, 0, 32'hDEAD_BEEF);
    row(0, 0, 1, 4'h9, 32'h0,        32'h0,        4,  1, 0, 4'hF, 1, 32'h1E);
    row(0, 0, 1, 4'hF, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'h1E);
    row(0, 0, 0, 4'h0, 32'h0,        32'h0,        4,  1, 0, 4'hF, 0, 32'h1E);

    @(negedge clk);
    foreach (tbl[i]) begin
      reset = tbl[i].rst; req = tbl[i].rq; in_valid = tbl[i].vld;
      in_op = tbl[i].op; in_a = tbl[i].a; in_b = tbl[i].b; mdu_lat = tbl[i].lat;
      #2;
      if (!tbl[i].rst) begin
        chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
        chk($sformatf("tbl%0d mdu_start", i), 32'(mdu_start), 32'(tbl[i].e_st));
        chk($sformatf("tbl%0d mdu_op", i), 32'(mdu_op), 32'(tbl[i].e_op));
        chk($sformatf("tbl%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rdv));
        chk($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].e_rdd);
        chk($sformatf("tbl%0d err", i), 32'(err), 32'h0);
      end
      @(negedge clk);
    end

    // Stuck-busy MDU: err after TO WAIT cycles, sticky, then reset inside a div's WAIT
    step(1, 0, 0, 4'h0, 32'h0, 32'h0);
    mdu_lat = 40;
    step(0, 0, 1, 4'h0, 32'd3, 32'hFFFF_FFFC);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < TO; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("err_before_timeout", 32'(err), 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("err_at_timeout", 32'(err), 32'h1);
    chk("ready_at_timeout", 32'(in_ready), 32'h1);
    step(0, 0, 1, 4'h4, 32'h0, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("err_sticky", 32'(err), 32'h1);
    chk("mfhi_after_timeout", rd_data, 32'hFFFF_FFFF);
    mdu_lat = 8;
    step(0, 0, 1, 4'h2, 32'd100, 32'd7);
    step(0, 0, 1, 4'h4, 32'h0, 32'h0);
    step(0, 0, 1, 4'h4, 32'h0, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("ready_low_in_wait", 32'(in_ready), 32'h0);
    step(1, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_mdu_start", 32'(mdu_start), 32'h0);
    chk("rst_mdu_op", 32'(mdu_op), 32'hF);
    chk("rst_mdu_a", mdu_a, 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Random traffic against the reference model
    step(1, 0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic        r, q, v;
      logic [3:0]  op;
      logic [31:0] a, b;
      r  = ($urandom_range(0, 249) == 0);
      q  = ($urandom_range(0, 11) == 0);
      v  = ($urandom_range(0, 2) != 0);
      op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
      case ($urandom_range(0, 19))
        0: mdu_lat = 15;
        1: mdu_lat = 16;
        2: mdu_lat = 30;
        default: mdu_lat = $urandom_range(1, 10);
      endcase
      step(r, q, v, op, a, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
